// File: rtl/cplx_acc_dump.sv
// Integrate-and-dump for complex multiplier products: sums ACC_LEN I/Q samples,
// then rounds, shifts and saturates the block sum onto a valid/ready output.
module cplx_acc_dump #(
  parameter int IN_W    = 36,
  parameter int OUT_W   = 18,
  parameter int ACC_LEN = 16,
  parameter int SHIFT   = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [IN_W-1:0]  data_i_i,
  input  logic signed [IN_W-1:0]  data_q_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic signed [OUT_W-1:0] data_i_o,
  output logic signed [OUT_W-1:0] data_q_o,
  output logic                    sat_o
);

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam int ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic signed [ACC_W:0] ONE_C   = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W:0] RND_C   = (SHIFT > 0) ? (ONE_C <<< ((SHIFT > 0) ? SHIFT - 1 : 0))
                                                          : {(ACC_W + 1){1'b0}};
  localparam logic signed [ACC_W:0] MAX_C   = (ONE_C <<< (OUT_W - 1)) - ONE_C;
  localparam logic signed [ACC_W:0] MIN_C   = ~MAX_C;

  // Round half up, then arithmetic shift; with SHIFT=0 the rounding constant is zero.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] t;
    t = v + RND_C;
    return t >>> SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
    logic [OUT_W:0] res;
    if (r > MAX_C) begin
      res = {1'b1, MAX_C[OUT_W-1:0]};
    end else if (r < MIN_C) begin
      res = {1'b1, MIN_C[OUT_W-1:0]};
    end else begin
      res = {1'b0, r[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic signed [ACC_W-1:0] acc_i_r;
  logic signed [ACC_W-1:0] acc_q_r;
  logic        [CNT_W-1:0] cnt_r;
  logic signed [ACC_W-1:0] sum_i_s;
  logic signed [ACC_W-1:0] sum_q_s;
  logic        [OUT_W:0]   dump_i_s;
  logic        [OUT_W:0]   dump_q_s;
  logic                    last_cnt_s;
  logic                    accept_s;
  logic                    last_s;

  // Handshake decode and the dump datapath for the completing sample.
  always_comb begin
    last_cnt_s = (cnt_r == LAST_CNT);
    // Only the completing sample stalls, and only while a result is still held.
    ready_o    = ~(last_cnt_s & valid_o & ~ready_i);
    accept_s   = valid_i & ready_o & ~clear_i;
    last_s     = accept_s & last_cnt_s;
    sum_i_s    = acc_i_r + ACC_W'(data_i_i);
    sum_q_s    = acc_q_r + ACC_W'(data_q_i);
    dump_i_s   = saturate(round_shift((ACC_W + 1)'(sum_i_s)));
    dump_q_s   = saturate(round_shift((ACC_W + 1)'(sum_q_s)));
  end

  // Accumulators and sample counter; clear wins over a coincident last sample.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_i_r <= {ACC_W{1'b0}};
      acc_q_r <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (clear_i || last_s) begin
      acc_i_r <= {ACC_W{1'b0}};
      acc_q_r <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_i_r <= sum_i_s;
      acc_q_r <= sum_q_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end else begin
      acc_i_r <= acc_i_r;
      acc_q_r <= acc_q_r;
      cnt_r   <= cnt_r;
    end
  end

  // Output holding registers: reload on block completion, retire on ready_i.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_o  <= 1'b0;
      data_i_o <= {OUT_W{1'b0}};
      data_q_o <= {OUT_W{1'b0}};
      sat_o    <= 1'b0;
    end else if (last_s) begin
      valid_o  <= 1'b1;
      data_i_o <= dump_i_s[OUT_W-1:0];
      data_q_o <= dump_q_s[OUT_W-1:0];
      sat_o    <= dump_i_s[OUT_W] | dump_q_s[OUT_W];
    end else if (valid_o && ready_i) begin
      valid_o  <= 1'b0;
      data_i_o <= data_i_o;
      data_q_o <= data_q_o;
      sat_o    <= sat_o;
    end else begin
      valid_o  <= valid_o;
      data_i_o <= data_i_o;
      data_q_o <= data_q_o;
      sat_o    <= sat_o;
    end
  end

endmodule

// File: tb/tb_cplx_acc_dump.sv
// Bench for cplx_acc_dump: directed scenarios plus random traffic, checked
// against a block-sum reference model built from queues of accepted samples.
module tb_cplx_acc_dump;

  localparam int IN_W    = 36;
  localparam int OUT_W   = 18;
  localparam int ACC_LEN = 4;
  localparam int SHIFT   = 2;

  logic clk_i   = 1'b0;
  logic arst_i  = 1'b1;
  logic clear_i = 1'b0;
  logic valid_i = 1'b0;
  logic ready_i = 1'b0;
  logic signed [IN_W-1:0]  data_i_i = '0;
  logic signed [IN_W-1:0]  data_q_i = '0;
  logic                    ready_o;
  logic                    valid_o;
  logic                    sat_o;
  logic signed [OUT_W-1:0] data_i_o;
  logic signed [OUT_W-1:0] data_q_o;

  int checks   = 0;
  int failures = 0;

  longint m_qi[$];
  longint m_qq[$];
  bit     m_valid;
  longint m_di;
  longint m_dq;
  bit     m_sat;

  cplx_acc_dump #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_LEN(ACC_LEN), .SHIFT(SHIFT)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .clear_i(clear_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_i_i(data_i_i), .data_q_i(data_q_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_i_o(data_i_o),
    .data_q_o(data_q_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_dump(input longint s, output bit sat);
    longint hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    longint lo = -hi - 1;
    longint r;
    if (SHIFT == 0) r = s;
    else            r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    m_qi.delete(); m_qq.delete();
    m_valid = 1'b0; m_di = 0; m_dq = 0; m_sat = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit v, input longint di, input longint dq,
                      input bit clr, input bit rdy, output bit took);
    bit exp_rdy, s1, s2;
    longint si, sq;
    valid_i = v; data_i_i = IN_W'(di); data_q_i = IN_W'(dq);
    clear_i = clr; ready_i = rdy;
    #1;
    exp_rdy = !((m_qi.size() == ACC_LEN - 1) && m_valid && !rdy);
    check("ready_o", ready_o, exp_rdy);
    @(posedge clk_i);
    took = v && exp_rdy && !clr;
    if (clr) begin m_qi.delete(); m_qq.delete(); end
    if (took) begin m_qi.push_back(di); m_qq.push_back(dq); end
    if (m_qi.size() == ACC_LEN) begin
      si = 0; sq = 0;
      foreach (m_qi[k]) begin si += m_qi[k]; sq += m_qq[k]; end
      m_di = ref_dump(si, s1); m_dq = ref_dump(sq, s2);
      m_sat = s1 | s2; m_valid = 1'b1;
      m_qi.delete(); m_qq.delete();
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk_i);
    check("valid_o", valid_o, m_valid);
    if (m_valid) begin
      check("data_i_o", data_i_o, m_di);
      check("data_q_o", data_q_o, m_dq);
      check("sat_o", sat_o, m_sat);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_di"}, data_i_o, 0);
    check({tag, "_dq"}, data_q_o, 0);
    check({tag, "_sat"}, sat_o, 0);
    check({tag, "_ready"}, ready_o, 1);
  endtask

  initial begin
    bit t;
    int n, stall;
    longint rs[4];
    longint rx[4];
    longint big_i, big_q;

    #1 check_zero("reset");
    @(negedge clk_i);
    arst_i = 1'b0;
    model_reset();

    // Basic block
    for (int k = 0; k < 4; k++) step(1'b1, 100 * (k + 1), -4, 1'b0, 1'b1, t);
    check("basic_i", data_i_o, 250);
    check("basic_q", data_q_o, -4);
    check("basic_sat", sat_o, 0);
    step(1'b0, 0, 0, 1'b0, 1'b1, t);
    check("basic_drop", valid_o, 0);

    // Rounding of tie and near-tie sums
    rs = '{6, 5, -6, -5};
    rx = '{2, 1, -1, -1};
    for (int b = 0; b < 4; b++) begin
      step(1'b1, rs[b], 0, 1'b0, 1'b1, t);
      for (int k = 0; k < 3; k++) step(1'b1, 0, 0, 1'b0, 1'b1, t);
      check("round_i", data_i_o, rx[b]);
    end
    step(1'b0, 0, 0, 1'b0, 1'b1, t);

    // Saturation both ways
    big_i = (longint'(1) <<< 34) - 1;
    big_q = -(longint'(1) <<< 35);
    for (int k = 0; k < 4; k++) step(1'b1, big_i, big_q, 1'b0, 1'b1, t);
    check("sat_i", data_i_o, 131071);
    check("sat_q", data_q_o, -131072);
    check("sat_flag", sat_o, 1);
    step(1'b0, 0, 0, 1'b0, 1'b1, t);

    // Backpressure: 8 back-to-back samples, 8th stalls until ready_i rises
    n = 0; stall = 0;
    for (int g = 0; g < 40 && n < 8; g++) begin
      step(1'b1, 10 + n, -n, 1'b0, (n == 7) && (stall >= 3), t);
      if (t) n++;
      else if (n == 7) begin
        stall++;
        check("bp_hold_i", data_i_o, 12);
        check("bp_hold_q", data_q_o, -1);
        check("bp_stall_ready", ready_o, 0);
      end
    end
    check("bp_done", n, 8);
    check("bp_blk2_valid", valid_o, 1);
    check("bp_blk2_i", data_i_o, 16);
    check("bp_blk2_q", data_q_o, -5);
    step(1'b0, 0, 0, 1'b0, 1'b1, t);

    // Clear discards partial block and the sample on the clear cycle
    step(1'b1, 1000, 0, 1'b0, 1'b1, t);
    step(1'b1, 1000, 0, 1'b0, 1'b1, t);
    step(1'b1, 1000, 0, 1'b1, 1'b1, t);
    for (int k = 0; k < 4; k++) step(1'b1, 4, 0, 1'b0, 1'b1, t);
    check("clear_i_res", data_i_o, 4);
    step(1'b0, 0, 0, 1'b0, 1'b1, t);

    // Reset mid-block
    step(1'b1, 5000, 5000, 1'b0, 1'b1, t);
    step(1'b1, 5000, 5000, 1'b0, 1'b1, t);
    valid_i = 1'b0; arst_i = 1'b1;
    #1 check_zero("rst_mid");
    @(negedge clk_i);
    arst_i = 1'b0; model_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 7, -7, 1'b0, 1'b1, t);
    check("rst_mid_after_i", data_i_o, 7);
    check("rst_mid_after_q", data_q_o, -7);

    // Reset while a result is held
    for (int k = 0; k < 4; k++) step(1'b1, 40, 40, 1'b0, 1'b0, t);
    check("rst_hold_pre", valid_o, 1);
    valid_i = 1'b0; arst_i = 1'b1;
    #1 check_zero("rst_hold");
    @(negedge clk_i);
    arst_i = 1'b0; model_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 8, 0, 1'b0, 1'b1, t);
    check("rst_hold_after_i", data_i_o, 8);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      longint di, dq;
      if ($urandom_range(0, 3) == 0) begin
        di = longint'({$urandom(), $urandom()}) >>> 28;
        dq = longint'({$urandom(), $urandom()}) >>> 28;
      end else begin
        di = longint'($urandom_range(0, 400000)) - 200000;
        dq = longint'($urandom_range(0, 400000)) - 200000;
      end
      step($urandom_range(0, 3) != 0, di, dq, $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) != 0, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
